// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: operating modes and the one-shot FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'b00,
        SATURATE = 2'b01,
        ONESHOT  = 2'b10,
        RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } oneshot_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is asserted on every PRESCALE-th enabled cycle.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sync_clr,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next enabled-cycle count; holds while enable is low
    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Enabled-cycle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With PRESCALE=1 the counter stays at zero, so tick follows enable
    assign tick = enable && !sync_clr && (cnt_q == LAST);

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot modes,
// a terminal-count pulse and a sticky over/underflow flag.
module updown_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_VALUE  = 2**DATA_WIDTH - 1,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  tc,
    output logic                  done,
    output logic                  overflow
);

    import counter_pkg::*;

    localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX_VALUE);

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  tc_q, tc_d;
    logic                  ovf_q, ovf_d;
    oneshot_state_e        state_q, state_d;

    mode_e                 mode_s;
    logic                  oneshot_s;
    logic                  start_s;
    logic                  tick_s;
    logic [DATA_WIDTH-1:0] term_s;
    logic [DATA_WIDTH-1:0] init_s;
    logic [DATA_WIDTH-1:0] step_s;
    logic                  at_term_s;

    assign mode_s    = mode_e'(mode);
    assign oneshot_s = (mode_s == ONESHOT);
    assign start_s   = start && oneshot_s;
    assign term_s    = up_down ? MAX_V : '0;
    // Wrap target and one-shot start value are both the opposite end of the range
    assign init_s    = up_down ? '0 : MAX_V;
    assign step_s    = up_down ? (count_q + DATA_WIDTH'(1)) : (count_q - DATA_WIDTH'(1));
    assign at_term_s = (count_q == term_s);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sync_clr (clear | load | start_s),
        .tick     (tick_s)
    );

    // Next-state: clear > load > start > tick step
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (oneshot_s) begin
            state_d = state_q;
        end else begin
            state_d = IDLE;
        end

        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end else if (load) begin
            count_d = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (start_s) begin
            count_d = init_s;
            state_d = RUN;
        end else if (tick_s) begin
            if (oneshot_s) begin
                if (state_q == RUN) begin
                    if (at_term_s) begin
                        state_d = DONE;
                    end else begin
                        count_d = step_s;
                        tc_d    = (step_s == term_s);
                        state_d = (step_s == term_s) ? DONE : RUN;
                    end
                end else begin
                    count_d = count_q;
                end
            end else if (!at_term_s) begin
                count_d = step_s;
                tc_d    = (step_s == term_s);
            end else if (mode_s == SATURATE) begin
                ovf_d = 1'b1;
            end else begin
                count_d = init_s;
                ovf_d   = 1'b1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter instances (wrap/sat, one-shot, prescaled) on shared stimulus.
module tb_updown_counter;

    localparam logic [1:0] SEL_W = 2'd0;
    localparam logic [1:0] SEL_O = 2'd1;
    localparam logic [1:0] SEL_P = 2'd2;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] cnt;
        logic       tc;
        logic       done;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       up_down = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       start = 1'b0;

    logic [3:0] cnt_w, cnt_o, cnt_p;
    logic       tc_w, tc_o, tc_p;
    logic       done_w, done_o, done_p;
    logic       ovf_w, ovf_o, ovf_p;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    updown_counter #(.DATA_WIDTH(4), .MAX_VALUE(9), .PRESCALE(1)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down), .mode(mode), .start(start),
        .count(cnt_w), .tc(tc_w), .done(done_w), .overflow(ovf_w));

    updown_counter #(.DATA_WIDTH(4), .MAX_VALUE(5), .PRESCALE(1)) dut_o (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down), .mode(mode), .start(start),
        .count(cnt_o), .tc(tc_o), .done(done_o), .overflow(ovf_o));

    updown_counter #(.DATA_WIDTH(4), .MAX_VALUE(9), .PRESCALE(3)) dut_p (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down), .mode(mode), .start(start),
        .count(cnt_p), .tc(tc_p), .done(done_p), .overflow(ovf_p));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [3:0] c, input logic t,
                        input logic d, input logic o, input string tag);
        exp_t e;
        e.sel = sel; e.cnt = c; e.tc = t; e.done = d; e.ovf = o;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t       e;
        string      tag;
        logic [6:0] obs;
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        case (e.sel)
            SEL_W:   obs = {cnt_w, tc_w, done_w, ovf_w};
            SEL_O:   obs = {cnt_o, tc_o, done_o, ovf_o};
            SEL_P:   obs = {cnt_p, tc_p, done_p, ovf_p};
            default: obs = 7'd0;
        endcase
        check_val({tag, ".count"},    32'(obs[6:3]), 32'(e.cnt));
        check_val({tag, ".tc"},       32'(obs[2]),   32'(e.tc));
        check_val({tag, ".done"},     32'(obs[1]),   32'(e.done));
        check_val({tag, ".overflow"}, 32'(obs[0]),   32'(e.ovf));
    endtask

    // one clock with inputs as currently driven, then compare against expectation
    task automatic cyc(input logic [1:0] sel, input logic [3:0] c, input logic t,
                       input logic d, input logic o, input string tag);
        push(sel, c, t, d, o, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input logic [1:0] sel, input logic [3:0] c, input logic t,
                             input logic d, input logic o, input string tag);
        push(sel, c, t, d, o, tag);
        check_out();
    endtask

    initial begin
        logic       p_en  [14] = '{1,1,1,1,1,1,1,1,1,1,0,0,1,1};
        logic [3:0] p_cnt [14] = '{0,0,1,1,1,2,2,2,3,3,3,3,3,4};

        #1 rst = 1'b1;
        #2;
        check_now(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "reset_w");
        check_now(SEL_O, 4'd0, 1'b0, 1'b0, 1'b0, "reset_o");
        rst = 1'b0;

        // wrap, up, MAX 9: tc at 9, then wrap to 0 with overflow
        mode = 2'b00; up_down = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 10; i++)
            cyc(SEL_W, 4'(i % 10), (i == 9), 1'b0, (i == 10), "wrap_up");
        enable = 1'b0; clear = 1'b1;
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "clear_w");
        clear = 1'b0;

        // saturate, down, load 2 on the first enabled cycle
        mode = 2'b01; up_down = 1'b0; enable = 1'b1; load = 1'b1; load_value = 4'd2;
        cyc(SEL_W, 4'd2, 1'b0, 1'b0, 1'b0, "sat_load");
        load = 1'b0;
        cyc(SEL_W, 4'd1, 1'b0, 1'b0, 1'b0, "sat_dn1");
        cyc(SEL_W, 4'd0, 1'b1, 1'b0, 1'b0, "sat_dn0");
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b1, "sat_hold1");
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b1, "sat_hold2");
        enable = 1'b0; clear = 1'b1;
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "clear_sat");
        clear = 1'b0;

        // one-shot, up, MAX 5
        mode = 2'b10; up_down = 1'b1; start = 1'b1;
        cyc(SEL_O, 4'd0, 1'b0, 1'b0, 1'b0, "os_start");
        start = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 10; i++)
            cyc(SEL_O, (i < 5) ? 4'(i) : 4'd5, (i == 5), (i >= 5), 1'b0, "os_run");
        enable = 1'b0; start = 1'b1;
        cyc(SEL_O, 4'd0, 1'b0, 1'b0, 1'b0, "os_restart");
        start = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 3; i++)
            cyc(SEL_O, 4'(i), 1'b0, 1'b0, 1'b0, "os_run_a");
        start = 1'b1;
        cyc(SEL_O, 4'd0, 1'b0, 1'b0, 1'b0, "os_restart_run");
        start = 1'b0;
        for (int i = 1; i <= 5; i++)
            cyc(SEL_O, 4'(i), (i == 5), (i == 5), 1'b0, "os_run_b");
        mode = 2'b00; enable = 1'b0;
        cyc(SEL_O, 4'd5, 1'b0, 1'b0, 1'b0, "os_leave");
        mode = 2'b10; load = 1'b1; load_value = 4'd3;
        cyc(SEL_O, 4'd3, 1'b0, 1'b0, 1'b0, "os_idle_load");
        load = 1'b0; enable = 1'b1;
        cyc(SEL_O, 4'd3, 1'b0, 1'b0, 1'b0, "os_idle_hold1");
        cyc(SEL_O, 4'd3, 1'b0, 1'b0, 1'b0, "os_idle_hold2");

        // prescale 3, wrap up, with a two-cycle enable gap
        enable = 1'b0; clear = 1'b1;
        cyc(SEL_P, 4'd0, 1'b0, 1'b0, 1'b0, "clear_p");
        clear = 1'b0; mode = 2'b00; up_down = 1'b1;
        for (int i = 0; i < 14; i++) begin
            enable = p_en[i];
            cyc(SEL_P, p_cnt[i], 1'b0, 1'b0, 1'b0, $sformatf("presc_%0d", i));
        end

        // clear beats load; load clamps to MAX without tc
        enable = 1'b0; clear = 1'b1;
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "clear_w2");
        clear = 1'b0; load = 1'b1; load_value = 4'd5;
        cyc(SEL_W, 4'd5, 1'b0, 1'b0, 1'b0, "load5");
        clear = 1'b1; load_value = 4'd7;
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "clear_over_load");
        clear = 1'b0; load_value = 4'd15;
        cyc(SEL_W, 4'd9, 1'b0, 1'b0, 1'b0, "load_clamp");
        load = 1'b0;

        // asynchronous reset in the middle of a count
        enable = 1'b1;
        cyc(SEL_W, 4'd0, 1'b0, 1'b0, 1'b1, "wrap_ovf");
        for (int i = 1; i <= 6; i++)
            cyc(SEL_W, 4'(i), 1'b0, 1'b0, 1'b1, "pre_rst");
        rst = 1'b1;
        #2;
        check_now(SEL_W, 4'd0, 1'b0, 1'b0, 1'b0, "rst_async_w");
        check_now(SEL_P, 4'd0, 1'b0, 1'b0, 1'b0, "rst_async_p");
        rst = 1'b0;
        for (int i = 1; i <= 3; i++)
            cyc(SEL_P, (i == 3) ? 4'd1 : 4'd0, 1'b0, 1'b0, 1'b0, "post_rst_presc");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, count register width.
REQ-002 SHALL have parameter MAX_VALUE, default 2**DATA_WIDTH-1, upper terminal value (legal range 1..2**DATA_WIDTH-1).
REQ-003 SHALL have parameter PRESCALE, default 1, number of enabled cycles per count step (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  enables prescaler and counting.
REQ-007 SHALL have port clear  input  1  synchronous clear.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_value  input  DATA_WIDTH  value for load.
REQ-010 SHALL have port up_down  input  1  direction, 1 = up, 0 = down.
REQ-011 SHALL have port mode  input  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (behaves as WRAP).
REQ-012 SHALL have port start  input  1  ONESHOT start/restart strobe.
REQ-013 SHALL have port count  output  DATA_WIDTH  current count.
REQ-014 SHALL have port tc  output  1  terminal-count pulse.
REQ-015 SHALL have port done  output  1  ONESHOT complete, level.
REQ-016 SHALL have port overflow  output  1  sticky over/underflow flag.

Function
REQ-017 SHALL generate internal tick: PRESCALE=1 -> tick = enable; else tick high one cycle after every PRESCALE enabled cycles; prescaler holds while enable low.
REQ-018 SHALL apply priority clear > load > start > tick step, evaluated every cycle.
REQ-019 clear SHALL set count=0, tc=0, done=0, overflow=0, prescaler=0, FSM=IDLE next cycle.
REQ-020 load SHALL set count=min(load_value, MAX_VALUE) next cycle and reset prescaler; overflow/done unchanged.
REQ-021 Terminal value SHALL be MAX_VALUE when up_down=1, 0 when up_down=0.
REQ-022 On tick with count != terminal, count SHALL change by exactly +1 (up) or -1 (down).
REQ-023 WRAP, tick at terminal: count -> 0 (up) or MAX_VALUE (down); overflow set.
REQ-024 SATURATE, tick at terminal: count holds; overflow set.
REQ-025 tc SHALL be registered, high exactly one cycle, coinciding with the first cycle count equals terminal after a tick step; not asserted by load or clear.
REQ-026 ONESHOT FSM SHALL have states IDLE, RUN, DONE: IDLE/DONE + start -> RUN with count=0 (up) or MAX_VALUE (down); RUN steps on tick; step reaching terminal -> DONE; DONE holds count, ignores tick.
REQ-027 done SHALL equal (state == DONE); overflow SHALL never set in ONESHOT.
REQ-028 In IDLE (ONESHOT) count SHALL hold; start while RUN SHALL restart from initial value.
REQ-029 mode change away from ONESHOT SHALL force FSM to IDLE and clear done next cycle; WRAP/SATURATE counting ignores FSM and start.
REQ-030 up_down change SHALL take effect on the next tick without altering count.

Reset
REQ-031 rst high SHALL immediately force count=0, tc=0, done=0, overflow=0, prescaler=0, FSM=IDLE, regardless of clk, including mid-count.
REQ-032 First step after rst deassertion SHALL require a full PRESCALE enabled cycles.

Structure
REQ-033 Package counter_pkg SHALL hold mode_e enum (WRAP, SATURATE, ONESHOT, RSVD) and oneshot_state_e (IDLE, RUN, DONE).
REQ-034 Prescaler SHALL be sub-module tick_prescaler (params PRESCALE; ports clk, rst, enable, sync_clr, tick).

Verification
REQ-035 DATA_WIDTH=4, MAX_VALUE=9, WRAP, up, enable 10 cycles from 0 -> count 9 with tc on cycle 9, then 0 with overflow=1.
REQ-036 SATURATE, down, load 2, enable 5 cycles -> count 2,1,0,0,0; tc once at 0; overflow=1.
REQ-037 ONESHOT, up, MAX_VALUE=5, start then enable 10 cycles -> count 0..5, done=1, count stays 5; start -> count 0, done=0.
REQ-038 PRESCALE=3, WRAP, up, enable 9 cycles -> count 3; drop enable 2 cycles mid-sequence -> step delayed exactly 2 cycles.
REQ-039 clear and load same cycle (load_value 7) -> count 0; load_value 15 with MAX_VALUE=9 -> count 9, no tc.
REQ-040 rst asserted mid-count at 6 between clock edges -> count 0, overflow 0, done 0 immediately.
